// File: rtl/acs_metric_store.sv
// Ping-pong accumulated-metric buffer with running-minimum tracking and min-subtracted replay.
// Optional macro ACS_METRIC_NORM_EN compiles in the min-subtraction; otherwise raw metrics are replayed.
module acs_metric_store #(
  parameter int DEPTH = 16,
  parameter int MW    = 18
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clkEn,
  input  logic                     startFrame,
  input  logic                     metricInEn,
  input  logic [MW-1:0]            accMetricIn,
  input  logic                     metricRequest,
  output logic [MW-1:0]            accMetricOut,
  output logic                     metricOutEn,
  output logic                     blockDone,
  output logic [MW-1:0]            minMetric,
  output logic [$clog2(DEPTH)-1:0] minIndex,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [MW-1:0] mem [0:2*DEPTH-1];

  logic          wr_bank;
  logic          zero_bank;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_ptr;
  logic [MW-1:0] run_min;
  logic [AW-1:0] run_idx;

  logic          frame_start;
  logic          wr_en;
  logic          swap;
  logic          take_new;
  logic [MW-1:0] next_min;
  logic [AW-1:0] next_idx;
  logic [MW-1:0] rd_word;
  logic [MW-1:0] rd_val;

  // A frame restart wins over a coincident write, which is dropped.
  assign frame_start = clkEn & startFrame;
  assign wr_en       = metricInEn & ~frame_start;
  assign swap        = wr_en && (wr_addr == AW'(DEPTH - 1));

  always_comb begin
    take_new = (wr_addr == '0) || (accMetricIn < run_min);
    next_min = run_min;
    next_idx = run_idx;
    if (take_new) begin
      next_min = accMetricIn;
      next_idx = wr_addr;
    end
  end

  always_comb begin
    rd_word = mem[{~wr_bank, rd_ptr}];
`ifdef ACS_METRIC_NORM_EN
    rd_val  = rd_word - minMetric;
`else
    rd_val  = rd_word;
`endif
  end

  // Metric storage: never reset, zero_bank masks stale contents after a restart.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{wr_bank, wr_addr}] <= accMetricIn;
  end

  // Read stage: one-cycle latency from request to output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accMetricOut <= '0;
      metricOutEn  <= 1'b0;
    end else begin
      metricOutEn <= metricRequest;
      if (metricRequest)
        accMetricOut <= zero_bank ? '0 : rd_val;
    end
  end

  // Control: frame restart > bank swap > normal pointer increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank   <= 1'b0;
      zero_bank <= 1'b1;
      wr_addr   <= '0;
      rd_ptr    <= '0;
      run_min   <= '0;
      run_idx   <= '0;
      minMetric <= '0;
      minIndex  <= '0;
      overrun   <= 1'b0;
      blockDone <= 1'b0;
    end else begin
      blockDone <= 1'b0;
      if (frame_start) begin
        wr_addr   <= '0;
        rd_ptr    <= '0;
        run_min   <= '0;
        run_idx   <= '0;
        minMetric <= '0;
        minIndex  <= '0;
        overrun   <= 1'b0;
        zero_bank <= 1'b1;
      end else begin
        if (metricRequest)
          rd_ptr <= rd_ptr + 1'b1;
        if (wr_en) begin
          wr_addr <= wr_addr + 1'b1;
          run_min <= next_min;
          run_idx <= next_idx;
        end
        if (swap) begin
          wr_bank   <= ~wr_bank;
          zero_bank <= 1'b0;
          minMetric <= next_min;
          minIndex  <= next_idx;
          rd_ptr    <= '0;
          blockDone <= 1'b1;
          if (rd_ptr != '0)
            overrun <= 1'b1;
        end
      end
    end
  end

endmodule
